matrix_mac_engine: RTL and testbench

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matrix_mac_engine.sv | 188 ++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_engine.sv
// Matrix multiply-accumulate engine: computes C = A*B (or a single row of C), one element at a time,
// through an external read port. Define MAC_SATURATE_EN to clamp results and enable the sat flag.
module matrix_mac_engine #(
  parameter int N      = 10,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [IDX_W-1:0]  row_sel,
  output logic              rd_en,
  output logic [IDX_W-1:0]  a_row,
  output logic [IDX_W-1:0]  a_col,
  output logic [IDX_W-1:0]  b_row,
  output logic [IDX_W-1:0]  b_col,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_row,
  output logic [IDX_W-1:0]  wr_col,
  output logic [OUT_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);

  state_t             state_reg, state_next;
  logic               mode_reg;
  logic [IDX_W-1:0]   r_reg, c_reg, k_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic               data_vld_reg, first_reg;
  logic [IDX_W-1:0]   wr_row_reg, wr_col_reg;
  logic [OUT_W-1:0]   wr_data_reg;

  logic               accept, row_valid, last_k, last_elem;
  logic [ACC_W-1:0]   product, mac_next;

  assign accept    = (state_reg == IDLE) && start;
  assign row_valid = !mode || ({1'b0, row_sel} < N_EXT);
  assign last_k    = (k_reg == LAST_IDX);
  assign last_elem = (c_reg == LAST_IDX) && (mode_reg || (r_reg == LAST_IDX));
  assign product   = ACC_W'(a_rdata) * ACC_W'(b_rdata);
  assign mac_next  = first_reg ? product : acc_reg + product;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) state_next = row_valid ? RUN : DONE;
      end
      RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (last_k) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        wr_en      = 1'b1;
        busy       = 1'b1;
        state_next = last_elem ? DONE : RUN;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Indices only move on edges where rd_en rises or stays high, so read addresses hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_reg <= 1'b0;
      r_reg    <= '0;
      c_reg    <= '0;
      k_reg    <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg <= mode;
            if (row_valid) begin
              r_reg <= mode ? row_sel : '0;
              c_reg <= '0;
              k_reg <= '0;
            end
          end
        end
        RUN: begin
          if (!last_k) k_reg <= k_reg + 1'b1;
        end
        WRITE: begin
          if (!last_elem) begin
            k_reg <= '0;
            if (c_reg == LAST_IDX) begin
              c_reg <= '0;
              r_reg <= r_reg + 1'b1;
            end else begin
              c_reg <= c_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data arrives one cycle after rd_en; first_reg marks the k=0 product that restarts the sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg      <= '0;
      data_vld_reg <= 1'b0;
      first_reg    <= 1'b0;
    end else begin
      data_vld_reg <= rd_en;
      first_reg    <= rd_en && (k_reg == '0);
      if (data_vld_reg) acc_reg <= mac_next;
    end
  end

`ifdef MAC_SATURATE_EN
  logic overflow;
  logic sat_reg;

  assign overflow = |mac_next[ACC_W-1:OUT_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_reg <= 1'b0;
    end else if (accept) begin
      sat_reg <= 1'b0;
    end else if (state_reg == DRAIN && overflow) begin
      sat_reg <= 1'b1;
    end
  end

  assign sat = sat_reg;
`else
  assign sat = 1'b0;
`endif

  // Result is captured while DRAIN absorbs the final product, so it is stable for the WRITE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_row_reg  <= '0;
      wr_col_reg  <= '0;
      wr_data_reg <= '0;
    end else if (state_reg == DRAIN) begin
      wr_row_reg <= r_reg;
      wr_col_reg <= c_reg;
`ifdef MAC_SATURATE_EN
      wr_data_reg <= overflow ? {OUT_W{1'b1}} : mac_next[OUT_W-1:0];
`else
      wr_data_reg <= mac_next[OUT_W-1:0];
`endif
    end
  end

  assign a_row   = r_reg;
  assign a_col   = k_reg;
  assign b_row   = k_reg;
  assign b_col   = c_reg;
  assign wr_row  = wr_row_reg;
  assign wr_col  = wr_col_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Self-checking bench for matrix_mac_engine: table of jobs checked against a plain matrix-product model,
// plus hand sequences for reset abort and start handling.
module tb_matrix_mac_engine;
  localparam int N      = 10;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int OUT_W  = 8;
  localparam int IDX_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [IDX_W-1:0]  row_sel;
  logic              rd_en;
  logic [IDX_W-1:0]  a_row, a_col, b_row, b_col;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_row, wr_col;
  logic [OUT_W-1:0]  wr_data;
  logic              busy, done, sat;

  matrix_mac_engine #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .row_sel(row_sel),
    .rd_en(rd_en), .a_row(a_row), .a_col(a_col), .b_row(b_row), .b_col(b_col),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .done(done), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int data;
  } wr_t;

  typedef struct {
    bit m;
    int rs;
    int ap;
    int bp;
    bit tog;
    int hold;
    int exp_cycles;
    int exp_writes;
  } job_t;

  logic [DATA_W-1:0] mem_a [N][N];
  logic [DATA_W-1:0] mem_b [N][N];
  wr_t wr_q[$];
  int  rd_cnt = 0;
  int  overlap_cnt = 0;
  int  tests = 0;
  int  fails = 0;
  int  first_data = -1;

  // Synchronous read memory; garbage when not read so misaligned sampling shows up.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= mem_a[a_row][a_col];
      b_rdata <= mem_b[b_row][b_col];
    end else begin
      a_rdata <= DATA_W'($urandom);
      b_rdata <= DATA_W'($urandom);
    end
  end

  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (wr_en) wr_q.push_back('{int'(wr_row), int'(wr_col), int'(wr_data)});
    if (rd_en && wr_en) overlap_cnt++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int ap, input int bp);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        case (ap)
          0:       mem_a[i][j] = (i == j) ? 8'd1 : 8'd0;
          1:       mem_a[i][j] = 8'd255;
          2:       mem_a[i][j] = 8'($urandom_range(0, 255));
          default: mem_a[i][j] = 8'($urandom_range(0, 15));
        endcase
        case (bp)
          1:       mem_b[i][j] = 8'd255;
          2:       mem_b[i][j] = 8'($urandom_range(0, 255));
          4:       mem_b[i][j] = 8'(i * N + j + 1);
          default: mem_b[i][j] = 8'($urandom_range(0, 15));
        endcase
      end
    end
  endtask

  task automatic run_job(input bit m, input int rs, input bit tog, input int hold,
                         input int exp_cycles, input int exp_writes, input string tag);
    int     cnt;
    int     idx;
    longint s;
    longint exp_data;
    bit     exp_sat;
    @(negedge clk);
    wr_q.delete();
    rd_cnt = 0;
    overlap_cnt = 0;
    mode = m;
    row_sel = rs[IDX_W-1:0];
    start = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    while (!done && cnt < 5000) begin
      if (tog) begin
        start = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
        row_sel = IDX_W'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b1;
    mode = m;
    row_sel = rs[IDX_W-1:0];
    check($sformatf("%s cycles", tag), cnt, exp_cycles);
    check($sformatf("%s busy_at_done", tag), busy, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("%s done_held", tag), done, 1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s done_clear", tag), done, 0);
    check($sformatf("%s writes", tag), wr_q.size(), exp_writes);
    check($sformatf("%s reads", tag), rd_cnt, exp_writes * N);
    check($sformatf("%s rd_wr_overlap", tag), overlap_cnt, 0);
    exp_sat = 1'b0;
    idx = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (m && r != rs) continue;
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(mem_a[r][k]) * longint'(mem_b[k][c]);
`ifdef MAC_SATURATE_EN
        exp_data = (s > 255) ? 255 : s;
        if (s > 255) exp_sat = 1'b1;
`else
        exp_data = s % 256;
`endif
        if (idx < wr_q.size()) begin
          check($sformatf("%s wr_row[%0d]", tag, idx), wr_q[idx].row, r);
          check($sformatf("%s wr_col[%0d]", tag, idx), wr_q[idx].col, c);
          check($sformatf("%s wr_data[%0d]", tag, idx), wr_q[idx].data, exp_data);
        end
        idx++;
      end
    end
    check($sformatf("%s sat", tag), sat, exp_sat);
    first_data = (wr_q.size() > 0) ? wr_q[0].data : -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs[7];
    jobs[0] = '{1'b0, 0,  0, 4, 1'b0, 0, N*N*(N+2), N*N};
    jobs[1] = '{1'b1, 2,  2, 2, 1'b0, 0, N*(N+2),   N};
    jobs[2] = '{1'b0, 0,  1, 1, 1'b0, 3, N*N*(N+2), N*N};
    jobs[3] = '{1'b1, 10, 2, 2, 1'b0, 2, 0,         0};
    jobs[4] = '{1'b1, 15, 2, 2, 1'b0, 0, 0,         0};
    jobs[5] = '{1'b0, 0,  2, 2, 1'b1, 0, N*N*(N+2), N*N};
    jobs[6] = '{1'b1, 9,  3, 2, 1'b1, 1, N*(N+2),   N};

    reset = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    row_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {rd_en, wr_en, busy, done, sat, a_row, a_col, b_row, b_col,
                            wr_row, wr_col, wr_data}, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      fill(jobs[i].ap, jobs[i].bp);
      run_job(jobs[i].m, jobs[i].rs, jobs[i].tog, jobs[i].hold,
              jobs[i].exp_cycles, jobs[i].exp_writes, $sformatf("job%0d", i));
      if (i == 2) begin
`ifdef MAC_SATURATE_EN
        check("all255_first_data", first_data, 255);
`else
        check("all255_first_data", first_data, 10);
`endif
      end
    end

    // Reset abort in the middle of element (1,1), then a clean rerun.
    fill(2, 2);
    @(negedge clk);
    wr_q.delete();
    mode = 1'b0;
    row_sel = '0;
    start = 1'b1;
    @(posedge clk); #1;
    repeat (11 * (N + 2) + 3) @(posedge clk);
    #1;
    check("abort rd_en_before", rd_en, 1);
    check("abort a_row_before", a_row, 1);
    check("abort b_col_before", b_col, 1);
    check("abort a_col_before", a_col, 3);
    check("abort writes_before", wr_q.size(), 11);
    #1;
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("abort outputs_zero", {rd_en, wr_en, busy, done, sat, a_row, a_col, b_row, b_col,
                                 wr_row, wr_col, wr_data}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort writes_after", wr_q.size(), 11);
    @(negedge clk);
    reset = 1'b1;
    run_job(1'b0, 0, 1'b0, 0, N*N*(N+2), N*N, "rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
